// File: rtl/mem_resp_pkg.sv
// Shared types and constants for the mem_responder slice.
package mem_resp_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    localparam int CNT_W = 32;

endpackage

// File: rtl/mem_resp_clear_seq.sv
// Post-reset clear sweep: walks every memory entry once, then signals done.
module mem_resp_clear_seq
    import mem_resp_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int IDX   = $clog2(DEPTH)
) (
    input  logic           clk,
    input  logic           rst,
    output logic           clr_we,
    output logic [IDX-1:0] clr_idx,
    output logic           done
);

    localparam logic [IDX-1:0] LAST_IDX = IDX'(DEPTH - 1);

    state_t         state, state_nx;
    logic [IDX-1:0] idx, idx_nx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= CLEAR;
            idx   <= '0;
        end else begin
            state <= state_nx;
            idx   <= idx_nx;
        end
    end

    always_comb begin
        state_nx = state;
        idx_nx   = idx;
        clr_we   = 1'b0;
        done     = 1'b0;
        case (state)
            CLEAR: begin
                clr_we = 1'b1;
                idx_nx = idx + 1'b1;
                if (idx == LAST_IDX)
                    state_nx = RUN;
            end
            RUN: begin
                done = 1'b1;
            end
            default: state_nx = CLEAR;
        endcase
    end

    assign clr_idx = idx;

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder for a controller's load/store ports, cleared by a post-reset sweep.
// Define MEM_RESPONDER_FWD_EN to return store data on a same-cycle same-address load.
module mem_responder
    import mem_resp_pkg::*;
#(
    parameter int DATA_SIZE    = 32,
    parameter int ADDRESS_SIZE = 32,
    parameter int DEPTH        = 1024
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load_en,
    input  logic [ADDRESS_SIZE-1:0] load_addr,
    output logic [DATA_SIZE-1:0]    load_data,
    input  logic                    store_en,
    input  logic [ADDRESS_SIZE-1:0] store_addr,
    input  logic [DATA_SIZE-1:0]    store_data,
    output logic                    init_done,
    output logic                    addr_err,
    output logic [CNT_W-1:0]        load_cnt,
    output logic [CNT_W-1:0]        store_cnt
);

    localparam int IDX = $clog2(DEPTH);

    logic [DATA_SIZE-1:0] mem [DEPTH];

    logic           clr_we;
    logic [IDX-1:0] clr_idx;
    logic           run;

    logic [IDX-1:0]       load_idx, store_idx;
    logic                 load_in_range, store_in_range;
    logic                 load_ok, store_ok, load_err, store_err;
    logic [DATA_SIZE-1:0] rd_word;
    logic [CNT_W-1:0]     load_cnt_q, store_cnt_q;

    mem_resp_clear_seq #(
        .DEPTH (DEPTH),
        .IDX   (IDX)
    ) u_clear_seq (
        .clk     (clk),
        .rst     (rst),
        .clr_we  (clr_we),
        .clr_idx (clr_idx),
        .done    (run)
    );

    assign load_idx       = load_addr[IDX-1:0];
    assign store_idx      = store_addr[IDX-1:0];
    assign load_in_range  = (load_addr >> IDX) == '0;
    assign store_in_range = (store_addr >> IDX) == '0;

    assign load_ok   = run & load_en & load_in_range;
    assign store_ok  = run & store_en & store_in_range;
    assign load_err  = load_en & ~(run & load_in_range);
    assign store_err = store_en & ~(run & store_in_range);

    // Without forwarding the array is read before the edge that commits the store,
    // so a colliding load naturally sees the old contents.
`ifdef MEM_RESPONDER_FWD_EN
    logic collide;
    assign collide = load_ok & store_ok & (load_idx == store_idx);

    always_comb begin
        rd_word = mem[load_idx];
        if (collide)
            rd_word = store_data;
    end
`else
    always_comb begin
        rd_word = mem[load_idx];
    end
`endif

    always_ff @(posedge clk) begin
        if (clr_we)
            mem[clr_idx] <= '0;
        else if (store_ok)
            mem[store_idx] <= store_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            load_data   <= '0;
            addr_err    <= 1'b0;
            load_cnt_q  <= '0;
            store_cnt_q <= '0;
        end else begin
            if (load_en)
                load_data <= load_ok ? rd_word : '0;
            if (load_err | store_err)
                addr_err <= 1'b1;
            if (load_ok)
                load_cnt_q <= load_cnt_q + 1'b1;
            if (store_ok)
                store_cnt_q <= store_cnt_q + 1'b1;
        end
    end

    assign init_done = run;
    assign load_cnt  = load_cnt_q;
    assign store_cnt = store_cnt_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed self-checking bench for mem_responder at DEPTH=16, DATA_SIZE=32.
module tb_mem_responder;

    localparam int DATA_SIZE    = 32;
    localparam int ADDRESS_SIZE = 32;
    localparam int DEPTH        = 16;

    logic                    clk = 1'b0;
    logic                    rst = 1'b0;
    logic                    load_en = 1'b0;
    logic [ADDRESS_SIZE-1:0] load_addr = '0;
    logic [DATA_SIZE-1:0]    load_data;
    logic                    store_en = 1'b0;
    logic [ADDRESS_SIZE-1:0] store_addr = '0;
    logic [DATA_SIZE-1:0]    store_data = '0;
    logic                    init_done;
    logic                    addr_err;
    logic [31:0]             load_cnt;
    logic [31:0]             store_cnt;

    int vectors = 0;
    int miscompares = 0;

    mem_responder #(
        .DATA_SIZE    (DATA_SIZE),
        .ADDRESS_SIZE (ADDRESS_SIZE),
        .DEPTH        (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .load_en    (load_en),
        .load_addr  (load_addr),
        .load_data  (load_data),
        .store_en   (store_en),
        .store_addr (store_addr),
        .store_data (store_data),
        .init_done  (init_done),
        .addr_err   (addr_err),
        .load_cnt   (load_cnt),
        .store_cnt  (store_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        load_en    = 1'b0;
        store_en   = 1'b0;
        load_addr  = '0;
        store_addr = '0;
        store_data = '0;
    endtask

    // Reset, then run the full 16-cycle sweep so the block is in RUN.
    task automatic do_init();
        idle_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < DEPTH; i++) tick();
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        #2;
        vectors++;
        if (load_data !== 32'h0 || init_done !== 1'b0 || addr_err !== 1'b0 ||
            load_cnt !== 32'h0 || store_cnt !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_values: load_data=%h init_done=%b addr_err=%b load_cnt=%0d store_cnt=%0d, required all zero",
                     load_data, init_done, addr_err, load_cnt, store_cnt);
        end
        tick();
        rst = 1'b0;
        for (int i = 1; i <= DEPTH + 1; i++) begin
            tick();
            vectors++;
            if (init_done !== (i >= DEPTH)) begin
                miscompares++;
                $display("FAIL init_done_timing: cycle %0d init_done=%b, required %b", i, init_done, (i >= DEPTH));
            end
        end
        load_en = 1'b1; load_addr = 32'd5;
        tick();
        idle_inputs();
        vectors++;
        if (load_data !== 32'h0 || load_cnt !== 32'd1 || addr_err !== 1'b0) begin
            miscompares++;
            $display("FAIL idle_load5: load_data=%h load_cnt=%0d addr_err=%b, required 0 1 0", load_data, load_cnt, addr_err);
        end
    endtask

    task automatic test_store_load();
        do_init();
        store_en = 1'b1; store_addr = 32'd3; store_data = 32'hDEADBEEF;
        tick();
        idle_inputs();
        load_en = 1'b1; load_addr = 32'd3;
        tick();
        idle_inputs();
        vectors++;
        if (load_data !== 32'hDEADBEEF) begin
            miscompares++;
            $display("FAIL store_load: load_data=%h, required deadbeef", load_data);
        end
        vectors++;
        if (store_cnt !== 32'd1 || load_cnt !== 32'd1) begin
            miscompares++;
            $display("FAIL store_load_cnt: store_cnt=%0d load_cnt=%0d, required 1 1", store_cnt, load_cnt);
        end
        tick(); tick();
        vectors++;
        if (load_data !== 32'hDEADBEEF) begin
            miscompares++;
            $display("FAIL load_hold: load_data=%h, required deadbeef", load_data);
        end
        // load old contents of 3 while storing to 9 in the same cycle
        load_en = 1'b1; load_addr = 32'd3;
        store_en = 1'b1; store_addr = 32'd9; store_data = 32'h0BADF00D;
        tick();
        idle_inputs();
        load_en = 1'b1; load_addr = 32'd9;
        vectors++;
        if (load_data !== 32'hDEADBEEF) begin
            miscompares++;
            $display("FAIL concurrent_load: load_data=%h, required deadbeef", load_data);
        end
        tick();
        idle_inputs();
        vectors++;
        if (load_data !== 32'h0BADF00D || store_cnt !== 32'd2 || load_cnt !== 32'd3) begin
            miscompares++;
            $display("FAIL concurrent_store: load_data=%h store_cnt=%0d load_cnt=%0d, required 0badf00d 2 3",
                     load_data, store_cnt, load_cnt);
        end
    endtask

    task automatic test_collision();
        logic [31:0] exp_fwd;
`ifdef MEM_RESPONDER_FWD_EN
        exp_fwd = 32'h12345678;
`else
        exp_fwd = 32'h0000000A;
`endif
        do_init();
        store_en = 1'b1; store_addr = 32'd7; store_data = 32'hA;
        tick();
        load_en = 1'b1; load_addr = 32'd7;
        store_en = 1'b1; store_addr = 32'd7; store_data = 32'h12345678;
        tick();
        idle_inputs();
        vectors++;
        if (load_data !== exp_fwd) begin
            miscompares++;
            $display("FAIL collision: load_data=%h, required %h", load_data, exp_fwd);
        end
        load_en = 1'b1; load_addr = 32'd7;
        tick();
        idle_inputs();
        vectors++;
        if (load_data !== 32'h12345678 || addr_err !== 1'b0) begin
            miscompares++;
            $display("FAIL collision_after: load_data=%h addr_err=%b, required 12345678 0", load_data, addr_err);
        end
    endtask

    task automatic test_out_of_range();
        do_init();
        store_en = 1'b1; store_addr = 32'd0; store_data = 32'h55;
        tick();
        idle_inputs();
        load_en = 1'b1; load_addr = 32'd0;
        tick();
        idle_inputs();
        vectors++;
        if (load_data !== 32'h55 || addr_err !== 1'b0) begin
            miscompares++;
            $display("FAIL oor_setup: load_data=%h addr_err=%b, required 55 0", load_data, addr_err);
        end
        load_en = 1'b1; load_addr = 32'd16;
        tick();
        idle_inputs();
        vectors++;
        if (load_data !== 32'h0 || addr_err !== 1'b1 || load_cnt !== 32'd1 || store_cnt !== 32'd1) begin
            miscompares++;
            $display("FAIL oor_load: load_data=%h addr_err=%b load_cnt=%0d store_cnt=%0d, required 0 1 1 1",
                     load_data, addr_err, load_cnt, store_cnt);
        end
        store_en = 1'b1; store_addr = 32'h20; store_data = 32'h99;
        tick();
        idle_inputs();
        tick(); tick();
        load_en = 1'b1; load_addr = 32'd0;
        tick();
        idle_inputs();
        vectors++;
        if (load_data !== 32'h55 || addr_err !== 1'b1 || store_cnt !== 32'd1 || load_cnt !== 32'd2) begin
            miscompares++;
            $display("FAIL oor_store: load_data=%h addr_err=%b store_cnt=%0d load_cnt=%0d, required 55 1 1 2",
                     load_data, addr_err, store_cnt, load_cnt);
        end
    endtask

    task automatic test_sweep_access();
        idle_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        store_en = 1'b1; store_addr = 32'd2; store_data = 32'hFF;
        load_en = 1'b1; load_addr = 32'd0;
        tick();
        idle_inputs();
        vectors++;
        if (addr_err !== 1'b1 || store_cnt !== 32'd0 || load_cnt !== 32'd0 ||
            load_data !== 32'h0 || init_done !== 1'b0) begin
            miscompares++;
            $display("FAIL sweep_access: addr_err=%b store_cnt=%0d load_cnt=%0d load_data=%h init_done=%b, required 1 0 0 0 0",
                     addr_err, store_cnt, load_cnt, load_data, init_done);
        end
        for (int i = 5; i <= DEPTH; i++) tick();
        vectors++;
        if (init_done !== 1'b1) begin
            miscompares++;
            $display("FAIL sweep_done: init_done=%b, required 1", init_done);
        end
        load_en = 1'b1; load_addr = 32'd2;
        tick();
        idle_inputs();
        vectors++;
        if (load_data !== 32'h0 || load_cnt !== 32'd1 || addr_err !== 1'b1) begin
            miscompares++;
            $display("FAIL sweep_dropped: load_data=%h load_cnt=%0d addr_err=%b, required 0 1 1", load_data, load_cnt, addr_err);
        end
    endtask

    task automatic test_reset_restart();
        do_init();
        store_en = 1'b1; store_addr = 32'd1; store_data = 32'h77;
        tick();
        idle_inputs();
        load_en = 1'b1; load_addr = 32'd1;
        tick();
        idle_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        rst = 1'b1;
        #2;
        vectors++;
        if (load_data !== 32'h0 || store_cnt !== 32'h0 || load_cnt !== 32'h0 || init_done !== 1'b0) begin
            miscompares++;
            $display("FAIL midsweep_reset: load_data=%h store_cnt=%0d load_cnt=%0d init_done=%b, required 0 0 0 0",
                     load_data, store_cnt, load_cnt, init_done);
        end
        tick();
        rst = 1'b0;
        for (int i = 1; i <= DEPTH; i++) begin
            tick();
            if (i >= DEPTH - 1) begin
                vectors++;
                if (init_done !== (i == DEPTH)) begin
                    miscompares++;
                    $display("FAIL restart_timing: cycle %0d init_done=%b, required %b", i, init_done, (i == DEPTH));
                end
            end
        end
        load_en = 1'b1; load_addr = 32'd1;
        tick();
        idle_inputs();
        vectors++;
        if (load_data !== 32'h0) begin
            miscompares++;
            $display("FAIL restart_cleared: load_data=%h, required 0", load_data);
        end
        dut.store_cnt_q = 32'hFFFF_FFFF;
        store_en = 1'b1; store_addr = 32'd4; store_data = 32'h1;
        tick();
        idle_inputs();
        vectors++;
        if (store_cnt !== 32'h0) begin
            miscompares++;
            $display("FAIL store_cnt_wrap: store_cnt=%h, required 0", store_cnt);
        end
        store_en = 1'b1; store_addr = 32'd5; store_data = 32'h2;
        tick();
        idle_inputs();
        vectors++;
        if (store_cnt !== 32'h1) begin
            miscompares++;
            $display("FAIL store_cnt_after_wrap: store_cnt=%h, required 1", store_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_store_load();
        test_collision();
        test_out_of_range();
        test_sweep_access();
        test_reset_restart();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 The block SHALL have parameter DATA_SIZE, default 32, meaning the width of a memory word.
REQ-002 The block SHALL have parameter ADDRESS_SIZE, default 32, meaning the address width as driven by the memory controller.
REQ-003 The block SHALL have parameter DEPTH, default 1024, meaning the number of words; it SHALL be a power of 2, and IDX = clog2(DEPTH).
REQ-004 The block SHALL have input clk, 1 bit, the clock; reset is rst, asynchronous, active-high.
REQ-005 The block SHALL have the ports below, each listed as name, direction, width, meaning.
- rst, in, 1: asynchronous active-high reset.
- load_en, in, 1: read request for this cycle.
- load_addr, in, ADDRESS_SIZE: word address of the read.
- load_data, out, DATA_SIZE: read data, valid the cycle after load_en.
- store_en, in, 1: write request for this cycle.
- store_addr, in, ADDRESS_SIZE: word address of the write.
- store_data, in, DATA_SIZE: write data.
- init_done, out, 1: goes high once the post-reset clear sweep is complete.
- addr_err, out, 1: sticky flag for an out-of-range access or an access made during the sweep.
- load_cnt, out, 32: number of accepted loads.
- store_cnt, out, 32: number of accepted stores.

Function
REQ-006 The block SHALL act as the memory-side responder to the controller's load and store ports, and SHALL never apply backpressure.
REQ-007 The block SHALL contain a 2-state FSM with states CLEAR and RUN; reset SHALL enter CLEAR, with the sweep index at 0.
REQ-008 In CLEAR, the block SHALL write 0 to entry[idx] every cycle and increment idx; after the write to entry DEPTH-1 it SHALL go to RUN, with init_done asserted starting the next cycle.
REQ-009 In CLEAR, a load_en or store_en SHALL be ignored (no memory change, no counter change), SHALL set addr_err, and a load SHALL return 0 on the following cycle.
REQ-010 In RUN, a load_en in cycle N SHALL present mem[load_addr[IDX-1:0]] on load_data in cycle N+1, giving a fixed read latency of 1.
REQ-011 load_data SHALL hold its last value while load_en is low.
REQ-012 In RUN, a store_en SHALL write store_data to mem[store_addr[IDX-1:0]] at the clock edge that ends the cycle.
REQ-013 An address with any bit at or above IDX set SHALL be out of range.
- An out-of-range load SHALL return 0.
- An out-of-range store SHALL be dropped.
- Both cases SHALL set addr_err; such accesses are not counted.
REQ-014 load_cnt and store_cnt SHALL increment by 1 per accepted in-range RUN access, and SHALL wrap modulo 2^32.
REQ-015 A load and a store to different addresses in the same cycle SHALL both complete independently.
REQ-016 A load and a store to the same address in the same cycle SHALL follow REQ-024.
REQ-017 addr_err SHALL stay high until the next reset.

Reset
REQ-018 On rst, the outputs SHALL take these values: load_data=0, init_done=0, addr_err=0, load_cnt=0, store_cnt=0, state=CLEAR, idx=0.
REQ-019 An rst asserted mid-sweep or mid-run SHALL restart the sweep from entry 0.
REQ-020 Memory array contents SHALL NOT be reset directly; the CLEAR sweep is the only clearing mechanism.

Configuration
REQ-021 Macro MEM_RESPONDER_FWD_EN SHALL control write-to-read forwarding.
REQ-022 With MEM_RESPONDER_FWD_EN defined, a same-cycle, same-address load and store SHALL return store_data (new data) on load_data at N+1.
REQ-023 Without MEM_RESPONDER_FWD_EN, the same collision SHALL return the pre-write contents (old data).
REQ-024 The collision behaviour SHALL be exactly the one selected by MEM_RESPONDER_FWD_EN; all other behaviour SHALL be identical in both builds.

Structure
REQ-025 Shared package mem_resp_pkg SHALL hold:
- the state typedef {CLEAR, RUN};
- the counter width constant CNT_W=32.
REQ-026 The sweep FSM and its index counter SHALL be the sub-module mem_resp_clear_seq, with ports clk, rst, clr_we, clr_idx and done.
REQ-027 The memory array, read register, range check and counters SHALL stay in mem_responder.

Verification (DEPTH=16, DATA_SIZE=32)
REQ-028 Scenario: reset, then idle -> init_done low for 16 cycles and high from cycle 17; a load of address 5 then returns 0x0.
REQ-029 Scenario: store 0xDEADBEEF to address 3, then load address 3 on the next cycle -> load_data=0xDEADBEEF one cycle later; store_cnt=1, load_cnt=1.
REQ-030 Scenario: same-cycle store 0x12345678 and load to address 7, where address 7 holds 0xA -> load_data=0x12345678 with MEM_RESPONDER_FWD_EN, 0xA without; the next load of address 7 returns 0x12345678 in both builds.
REQ-031 Scenario: load of address 16 -> load_data=0, addr_err=1 and stays 1; counters unchanged; a store to address 0x20 leaves the memory unchanged.
REQ-032 Scenario: store_en during cycle 4 of the sweep -> dropped, addr_err=1, and the addressed entry reads 0 after init_done.
REQ-033 Scenario: rst pulsed at sweep cycle 9 -> sweep restarts from entry 0 and init_done rises 16 cycles after the rst deassertion; preload store_cnt to 0xFFFFFFFF via a backdoor, then one store -> store_cnt=0.
